// File: rtl/score_board.sv
// Score keeper and score renderer for the two-player ball game.
// Counts rising edges of each player's score flag, detects the winning score,
// and redraws both scores as 3x5 glyphs through the shared pixel-write path
// using a request/grant handshake with the pixel-write arbiter.
module score_board #(
  parameter logic [3:0] WIN_SCORE = 4'd7,
  parameter logic [7:0] X0        = 8'd20,
  parameter logic [6:0] Y0        = 7'd100,
  parameter logic [7:0] X1        = 8'd20,
  parameter logic [6:0] Y1        = 7'd14,
  parameter logic [2:0] FG_COLOR  = 3'b111
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       player_0_scores,
  input  logic       player_1_scores,
  input  logic       restart,
  input  logic       draw_grant,
  output logic       draw_req,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] color_out,
  output logic       writeEn,
  output logic [3:0] score_0,
  output logic [3:0] score_1,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {IDLE, REQ, DRAW0, DRAW1, DONE} state_t;

  state_t     r_state;
  logic       r_p0Prev;
  logic       r_p1Prev;
  logic       r_pending;
  logic [1:0] r_col;
  logic [2:0] r_row;
  logic [3:0] r_digit0;
  logic [3:0] r_digit1;

  logic       w_inc0;
  logic       w_inc1;
  logic [3:0] w_next0;
  logic [3:0] w_next1;
  logic       w_win0;
  logic       w_win1;
  logic       w_grantTake;
  logic       w_lastPix;
  logic [1:0] w_nextCol;
  logic [2:0] w_nextRow;

  // 3x5 glyph bitmaps, bit 14 is the top-left pixel, scanned row-major.
  function automatic logic [14:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b010_010_010_010_010;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      default: glyph = 15'b000_000_000_000_000;
    endcase
  endfunction

  // Colour of one glyph pixel: foreground when lit, black otherwise.
  function automatic logic [2:0] pixColor(input logic [3:0] d, input logic [2:0] row,
                                          input logic [1:0] col);
    logic [14:0] g;
    logic [3:0]  idx;
    g   = glyph(d);
    idx = 4'd14 - ({1'b0, row} * 4'd3 + {2'b00, col});
    pixColor = g[idx] ? FG_COLOR : 3'b000;
  endfunction

  // A score only counts on a fresh rising edge, while the match is live and
  // no restart is happening in the same cycle.
  assign w_inc0      = player_0_scores & ~r_p0Prev & ~game_over & ~restart;
  assign w_inc1      = player_1_scores & ~r_p1Prev & ~game_over & ~restart;
  assign w_next0     = score_0 + 4'd1;
  assign w_next1     = score_1 + 4'd1;
  assign w_win0      = w_inc0 && (w_next0 == WIN_SCORE);
  assign w_win1      = w_inc1 && (w_next1 == WIN_SCORE);
  assign w_grantTake = (r_state == REQ) && draw_grant;
  assign w_lastPix   = (r_col == 2'd2) && (r_row == 3'd4);
  assign w_nextCol   = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
  assign w_nextRow   = (r_col == 2'd2) ? r_row + 3'd1 : r_row;

  // Score counting, win detection and the redraw-pending flag; a new score
  // event beats the grant clearing pending so a mid-draw change is redrawn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_p0Prev  <= 1'b0;
      r_p1Prev  <= 1'b0;
      score_0   <= 4'd0;
      score_1   <= 4'd0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      r_pending <= 1'b1;
    end else begin
      r_p0Prev <= player_0_scores;
      r_p1Prev <= player_1_scores;
      if (restart) begin
        score_0   <= 4'd0;
        score_1   <= 4'd0;
        game_over <= 1'b0;
        winner    <= 1'b0;
        r_pending <= 1'b1;
      end else begin
        if (w_inc0) score_0 <= w_next0;
        if (w_inc1) score_1 <= w_next1;
        if (w_win0 || w_win1) begin
          game_over <= 1'b1;
          winner    <= ~w_win0;
        end
        if (w_inc0 || w_inc1) r_pending <= 1'b1;
        else if (w_grantTake) r_pending <= 1'b0;
      end
    end
  end

  // Draw sequencer with registered pixel outputs; each cycle in a DRAW state
  // presents the pixel addressed by the col/row counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_col     <= 2'd0;
      r_row     <= 3'd0;
      r_digit0  <= 4'd0;
      r_digit1  <= 4'd0;
      draw_req  <= 1'b0;
      writeEn   <= 1'b0;
      x_out     <= 8'd0;
      y_out     <= 7'd0;
      color_out <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pending) begin
            r_state  <= REQ;
            draw_req <= 1'b1;
          end
        end
        REQ: begin
          if (draw_grant) begin
            r_state   <= DRAW0;
            r_col     <= 2'd0;
            r_row     <= 3'd0;
            r_digit0  <= score_0;
            r_digit1  <= score_1;
            writeEn   <= 1'b1;
            x_out     <= X0;
            y_out     <= Y0;
            color_out <= pixColor(score_0, 3'd0, 2'd0);
          end
        end
        DRAW0: begin
          if (w_lastPix) begin
            r_state   <= DRAW1;
            r_col     <= 2'd0;
            r_row     <= 3'd0;
            x_out     <= X1;
            y_out     <= Y1;
            color_out <= pixColor(r_digit1, 3'd0, 2'd0);
          end else begin
            r_col     <= w_nextCol;
            r_row     <= w_nextRow;
            x_out     <= X0 + {6'd0, w_nextCol};
            y_out     <= Y0 + {4'd0, w_nextRow};
            color_out <= pixColor(r_digit0, w_nextRow, w_nextCol);
          end
        end
        DRAW1: begin
          if (w_lastPix) begin
            r_state   <= DONE;
            r_col     <= 2'd0;
            r_row     <= 3'd0;
            draw_req  <= 1'b0;
            writeEn   <= 1'b0;
            x_out     <= 8'd0;
            y_out     <= 7'd0;
            color_out <= 3'b000;
          end else begin
            r_col     <= w_nextCol;
            r_row     <= w_nextRow;
            x_out     <= X1 + {6'd0, w_nextCol};
            y_out     <= Y1 + {4'd0, w_nextRow};
            color_out <= pixColor(r_digit1, w_nextRow, w_nextCol);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
